pwm_capture: RTL and testbench

- Servo-PWM receiver; the decode side of the PWM_gen waveform format.
- Format: high time = 64 + duty clockdiv ticks; period = endcount + 1 ticks.
- Samples an external PWM line and measures high time and period.
- Recovers the 8-bit duty and emits a one-cycle latch strobe with error flags, so a captured servo command can be fed back into the servo controller path.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_sync_edge.sv | 28 ++
 rtl/pwm_capture.sv | 172 +++++++++++++++++
 tb/tb_pwm_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the servo-PWM capture path.
// Imported by pwm_capture.
package pwm_pkg;

    localparam int unsigned DUTY_OFFSET = 64;
    localparam int unsigned DUTY_MAX    = 255;
    localparam int unsigned CNT_MAX     = 4095;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Three-flop synchronizer for an asynchronous input, with single-cycle rise/fall pulses
// derived from the last two synchronized stages.
module pwm_sync_edge (
    input  logic clockdiv,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clockdiv) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_capture.sv
// Servo-PWM receiver: measures high time and rise-to-rise period of PWMIn and recovers the
// 8-bit duty (high time = DUTY_OFFSET + duty ticks), strobing latch once per complete period.
module pwm_capture #(
    parameter int unsigned DUTY_OFFSET = pwm_pkg::DUTY_OFFSET,
    parameter int unsigned CNT_W       = 12
) (
    input  logic             clockdiv,
    input  logic             reset,
    input  logic             PWMIn,
    input  logic [CNT_W-1:0] endcount,
    output logic [7:0]       duty,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             latch,
    output logic             range_err,
    output logic             period_err,
    output logic             timeout
);

    import pwm_pkg::*;

    localparam int unsigned DW = CNT_W + 1;
    localparam logic [CNT_W-1:0]  CntMax    = '1;
    localparam logic [CNT_W-1:0]  CntOne    = CNT_W'(1);
    localparam logic [CNT_W:0]    OffsetExt = DW'(DUTY_OFFSET);
    localparam logic signed [CNT_W:0] MaxExt = DW'(DUTY_MAX);

    logic rise, fall;

    pwm_sync_edge u_sync (
        .clockdiv (clockdiv),
        .reset    (reset),
        .sig_i    (PWMIn),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] width_r_q, width_r_d;
    logic [7:0]       duty_q, duty_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             latch_q, latch_d;
    logic             range_err_q, range_err_d;
    logic             period_err_q, period_err_d;
    logic             timeout_q, timeout_d;

    logic [CNT_W-1:0]   hcnt_inc, pcnt_inc;
    logic               pcnt_sat;
    logic signed [CNT_W:0] diff;
    logic [7:0]         duty_calc;
    logic               range_calc;
    logic [CNT_W:0]     period_exp;
    logic               period_calc;

    // Counters saturate rather than wrap so a stuck line reads as a long, not short, pulse.
    assign hcnt_inc = (hcnt_q == CntMax) ? hcnt_q : hcnt_q + CntOne;
    assign pcnt_inc = (pcnt_q == CntMax) ? pcnt_q : pcnt_q + CntOne;
    assign pcnt_sat = (pcnt_q == CntMax);

    assign diff = $signed({1'b0, width_r_q}) - $signed(OffsetExt);

    always_comb begin
        duty_calc  = diff[7:0];
        range_calc = 1'b0;
        if (diff[CNT_W]) begin
            duty_calc  = 8'd0;
            range_calc = 1'b1;
        end else if (diff > MaxExt) begin
            duty_calc  = 8'd255;
            range_calc = 1'b1;
        end
    end

    // One extra bit so endcount = all-ones still yields a representable expected period.
    assign period_exp  = {1'b0, endcount} + DW'(1);
    assign period_calc = ({1'b0, pcnt_q} != period_exp);

    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        pcnt_d       = pcnt_q;
        width_r_d    = width_r_q;
        duty_d       = duty_q;
        width_d      = width_q;
        period_d     = period_q;
        latch_d      = 1'b0;
        range_err_d  = range_err_q;
        period_err_d = period_err_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    hcnt_d  = CntOne;
                    pcnt_d  = CntOne;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                hcnt_d = hcnt_inc;
                pcnt_d = pcnt_inc;
                if (pcnt_sat) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else if (fall) begin
                    width_r_d = hcnt_q;
                    state_d   = StLow;
                end
            end
            StLow: begin
                pcnt_d = pcnt_inc;
                // A rise closes the period and takes priority over saturation.
                if (rise) begin
                    latch_d      = 1'b1;
                    width_d      = width_r_q;
                    period_d     = pcnt_q;
                    duty_d       = duty_calc;
                    range_err_d  = range_calc;
                    period_err_d = period_calc;
                    timeout_d    = 1'b0;
                    hcnt_d       = CntOne;
                    pcnt_d       = CntOne;
                    state_d      = StHigh;
                end else if (pcnt_sat) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clockdiv) begin
        if (!reset) begin
            state_q      <= StIdle;
            hcnt_q       <= '0;
            pcnt_q       <= '0;
            width_r_q    <= '0;
            duty_q       <= '0;
            width_q      <= '0;
            period_q     <= '0;
            latch_q      <= 1'b0;
            range_err_q  <= 1'b0;
            period_err_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            pcnt_q       <= pcnt_d;
            width_r_q    <= width_r_d;
            duty_q       <= duty_d;
            width_q      <= width_d;
            period_q     <= period_d;
            latch_q      <= latch_d;
            range_err_q  <= range_err_d;
            period_err_q <= period_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign duty       = duty_q;
    assign width      = width_q;
    assign period     = period_q;
    assign latch      = latch_q;
    assign range_err  = range_err_q;
    assign period_err = period_err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: generator-style waveforms with hand-computed captures,
// error flags, timeout timing and mid-measurement reset.
module tb_pwm_capture;

    logic        clockdiv = 1'b0;
    logic        reset    = 1'b0;
    logic        PWMIn    = 1'b0;
    logic [11:0] endcount = 12'd1999;
    logic [7:0]  duty;
    logic [11:0] width;
    logic [11:0] period;
    logic        latch;
    logic        range_err;
    logic        period_err;
    logic        timeout;

    pwm_capture dut (
        .clockdiv   (clockdiv),
        .reset      (reset),
        .PWMIn      (PWMIn),
        .endcount   (endcount),
        .duty       (duty),
        .width      (width),
        .period     (period),
        .latch      (latch),
        .range_err  (range_err),
        .period_err (period_err),
        .timeout    (timeout)
    );

    always #5 clockdiv = ~clockdiv;

    int unsigned cyc      = 0;
    int unsigned lat_cnt  = 0;
    int unsigned last_lat = 0;
    int unsigned prev_lat = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always @(posedge clockdiv) cyc <= cyc + 1;

    always @(negedge clockdiv) begin
        if (latch) begin
            lat_cnt  <= lat_cnt + 1;
            prev_lat <= last_lat;
            last_lat <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One generator period: high for h ticks, then low for p-h ticks.
    task automatic send(input int h, input int p);
        PWMIn = 1'b1;
        repeat (h) begin
            @(posedge clockdiv);
            #1;
        end
        PWMIn = 1'b0;
        repeat (p - h) begin
            @(posedge clockdiv);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_duty"}, 32'(duty), 32'd0);
        check({tag, "_width"}, 32'(width), 32'd0);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_latch"}, 32'(latch), 32'd0);
        check({tag, "_range_err"}, 32'(range_err), 32'd0);
        check({tag, "_period_err"}, 32'(period_err), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int dl[4];
        int unsigned lc;
        int unsigned tmo_cyc;
        dl = '{0, 1, 128, 255};

        repeat (4) @(posedge clockdiv);
        @(negedge clockdiv);
        check_all_zero("reset");
        @(posedge clockdiv);
        #1 reset = 1'b1;

        // Loopback, duty 100 with endcount 1999
        repeat (3) send(164, 2000);
        check("loop_latches", lat_cnt, 32'd2);
        check("loop_spacing", last_lat - prev_lat, 32'd2000);
        check("loop_width", 32'(width), 32'd164);
        check("loop_period", 32'(period), 32'd2000);
        check("loop_duty", 32'(duty), 32'd100);
        check("loop_range_err", 32'(range_err), 32'd0);
        check("loop_period_err", 32'(period_err), 32'd0);
        check("loop_timeout", 32'(timeout), 32'd0);

        foreach (dl[i]) begin
            repeat (2) send(64 + dl[i], 2000);
            check($sformatf("sweep_duty_%0d", dl[i]), 32'(duty), 32'(dl[i]));
            check($sformatf("sweep_width_%0d", dl[i]), 32'(width), 32'(64 + dl[i]));
            check($sformatf("sweep_range_%0d", dl[i]), 32'(range_err), 32'd0);
        end

        repeat (2) send(40, 2000);
        check("low_duty", 32'(duty), 32'd0);
        check("low_width", 32'(width), 32'd40);
        check("low_range_err", 32'(range_err), 32'd1);
        repeat (2) send(400, 2000);
        check("high_duty", 32'(duty), 32'd255);
        check("high_width", 32'(width), 32'd400);
        check("high_range_err", 32'(range_err), 32'd1);
        repeat (2) send(1, 2000);
        check("tick_width", 32'(width), 32'd1);
        check("tick_duty", 32'(duty), 32'd0);
        check("tick_range_err", 32'(range_err), 32'd1);

        repeat (2) send(164, 1500);
        check("mism_period", 32'(period), 32'd1500);
        check("mism_period_err", 32'(period_err), 32'd1);
        check("mism_duty", 32'(duty), 32'd100);
        check("mism_range_err", 32'(range_err), 32'd0);

        repeat (2) send(164, 2000);
        check("restore_period_err", 32'(period_err), 32'd0);

        // Line held low: timeout counts from the rise of the last period sent
        lc = lat_cnt;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clockdiv);
            if (timeout) break;
        end
        tmo_cyc = cyc;
        check("tmo_set", 32'(timeout), 32'd1);
        check("tmo_delay", tmo_cyc - last_lat, 32'd4095);
        check("tmo_duty_held", 32'(duty), 32'd100);
        check("tmo_no_latch", lat_cnt, lc);
        @(posedge clockdiv);
        #1;
        send(164, 2000);
        check("tmo_first_rise_latches", lat_cnt, lc);
        check("tmo_still_set", 32'(timeout), 32'd1);
        send(164, 2000);
        check("tmo_relatch", lat_cnt, lc + 1);
        check("tmo_cleared", 32'(timeout), 32'd0);
        check("tmo_width", 32'(width), 32'd164);
        check("tmo_period", 32'(period), 32'd2000);

        // Reset in the middle of a high phase
        PWMIn = 1'b1;
        repeat (50) begin
            @(posedge clockdiv);
            #1;
        end
        reset = 1'b0;
        PWMIn = 1'b0;
        repeat (3) @(posedge clockdiv);
        @(negedge clockdiv);
        check_all_zero("midrst");
        lc = lat_cnt;
        @(posedge clockdiv);
        #1 reset = 1'b1;
        repeat (5) begin
            @(posedge clockdiv);
            #1;
        end
        check("rst_no_spurious", lat_cnt, lc);
        send(164, 2000);
        check("rst_first_rise", lat_cnt, lc);
        send(164, 2000);
        check("rst_second_rise", lat_cnt, lc + 1);
        check("rst_width", 32'(width), 32'd164);
        check("rst_period", 32'(period), 32'd2000);
        check("rst_duty", 32'(duty), 32'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
